// File: rtl/exe_stage_pipe.sv
// Execute stage: barrel-shifted second operand, NZCV ALU, branch target adder,
// status register and the EXE/MEM pipeline register.
module exe_stage_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic        B,
    input  logic        S,
    input  logic        imm,
    input  logic [3:0]  exe_cmd,
    input  logic [31:0] PC,
    input  logic [31:0] val_Rn,
    input  logic [31:0] val_Rm,
    input  logic [11:0] shift_operand,
    input  logic [3:0]  dest,
    input  logic [3:0]  status_in,
    input  logic [23:0] signed_imm_24,
    input  logic        freeze,
    output logic        branch_taken,
    output logic [31:0] branch_address,
    output logic [3:0]  status_reg,
    output logic        wb_en_mem,
    output logic        mem_read_mem,
    output logic        mem_write_mem,
    output logic [31:0] alu_res,
    output logic [31:0] val_Rm_mem,
    output logic [3:0]  dest_mem
);

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] dbl;
        dbl = {x, x} >> n;
        return dbl[31:0];
    endfunction

    logic [31:0] val2_s;
    logic [4:0]  sh_amt_s;
    logic [32:0] wide_s;
    logic [31:0] alu_res_d;
    logic        n_s, z_s, c_s, v_s;
    logic [3:0]  status_d;

    logic [3:0]  status_q;
    logic        wb_en_q, mem_read_q, mem_write_q;
    logic [31:0] alu_res_q, val_Rm_q;
    logic [3:0]  dest_q;

    // Register-specified shifts use the immediate amount field as well.
    assign sh_amt_s = shift_operand[11:7];

    // Second operand: rotated immediate, raw offset for memory ops, or shifted Rm.
    always_comb begin
        val2_s = 32'd0;
        if (imm) begin
            val2_s = ror32({24'd0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
        end else if (mem_read_en | mem_write_en) begin
            val2_s = {20'd0, shift_operand};
        end else begin
            case (shift_operand[6:5])
                2'b00:   val2_s = val_Rm << sh_amt_s;
                2'b01:   val2_s = val_Rm >> sh_amt_s;
                2'b10:   val2_s = $unsigned($signed(val_Rm) >>> sh_amt_s);
                2'b11:   val2_s = ror32(val_Rm, sh_amt_s);
                default: val2_s = val_Rm;
            endcase
        end
    end

    // ALU result and flags; C/V default to the incoming status values.
    always_comb begin
        wide_s    = 33'd0;
        alu_res_d = 32'd0;
        c_s       = status_in[1];
        v_s       = status_in[0];
        case (exe_cmd)
            4'b0001: alu_res_d = val2_s;
            4'b1001: alu_res_d = ~val2_s;
            4'b0010, 4'b0011: begin
                wide_s    = {1'b0, val_Rn} + {1'b0, val2_s}
                          + {32'd0, (exe_cmd[0] & status_in[1])};
                alu_res_d = wide_s[31:0];
                c_s       = wide_s[32];
                v_s       = (val_Rn[31] == val2_s[31]) && (alu_res_d[31] != val_Rn[31]);
            end
            4'b0100, 4'b0101: begin
                // SBC subtracts the inverted carry; bit 32 is the borrow.
                wide_s    = {1'b0, val_Rn} - {1'b0, val2_s}
                          - {32'd0, (exe_cmd[0] & ~status_in[1])};
                alu_res_d = wide_s[31:0];
                c_s       = ~wide_s[32];
                v_s       = (val_Rn[31] != val2_s[31]) && (alu_res_d[31] != val_Rn[31]);
            end
            4'b0110: alu_res_d = val_Rn & val2_s;
            4'b0111: alu_res_d = val_Rn | val2_s;
            4'b1000: alu_res_d = val_Rn ^ val2_s;
            default: alu_res_d = 32'd0;
        endcase
        n_s      = alu_res_d[31];
        z_s      = (alu_res_d == 32'd0);
        status_d = {n_s, z_s, c_s, v_s};
    end

    // Status register: loads only on flag-setting, unfrozen instructions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q <= 4'd0;
        end else if (S && !freeze) begin
            status_q <= status_d;
        end
    end

    // EXE/MEM pipeline register, held while frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            alu_res_q   <= 32'd0;
            val_Rm_q    <= 32'd0;
            dest_q      <= 4'd0;
        end else if (!freeze) begin
            wb_en_q     <= wb_en;
            mem_read_q  <= mem_read_en;
            mem_write_q <= mem_write_en;
            alu_res_q   <= alu_res_d;
            val_Rm_q    <= val_Rm;
            dest_q      <= dest;
        end
    end

    assign branch_taken   = B;
    assign branch_address = PC + {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};
    assign status_reg     = status_q;
    assign wb_en_mem      = wb_en_q;
    assign mem_read_mem   = mem_read_q;
    assign mem_write_mem  = mem_write_q;
    assign alu_res        = alu_res_q;
    assign val_Rm_mem     = val_Rm_q;
    assign dest_mem       = dest_q;

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Scoreboard bench for exe_stage_pipe: directed vectors push expected
// EXE/MEM + status contents, a monitor pops and compares after each edge.
module tb_exe_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en, mem_read_en, mem_write_en, B, S, imm, freeze;
    logic [3:0]  exe_cmd, dest, status_in;
    logic [31:0] PC, val_Rn, val_Rm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [3:0]  status_reg;
    logic        wb_en_mem, mem_read_mem, mem_write_mem;
    logic [31:0] alu_res, val_Rm_mem;
    logic [3:0]  dest_mem;

    typedef struct {
        logic [31:0] alu;
        logic [3:0]  st;
        logic        wb;
        logic        mr;
        logic        mw;
        logic [31:0] rm;
        logic [3:0]  dst;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;

    exe_stage_pipe dut (
        .clk(clk), .rst(rst), .wb_en(wb_en), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .B(B), .S(S), .imm(imm), .exe_cmd(exe_cmd),
        .PC(PC), .val_Rn(val_Rn), .val_Rm(val_Rm), .shift_operand(shift_operand),
        .dest(dest), .status_in(status_in), .signed_imm_24(signed_imm_24),
        .freeze(freeze), .branch_taken(branch_taken), .branch_address(branch_address),
        .status_reg(status_reg), .wb_en_mem(wb_en_mem), .mem_read_mem(mem_read_mem),
        .mem_write_mem(mem_write_mem), .alu_res(alu_res), .val_Rm_mem(val_Rm_mem),
        .dest_mem(dest_mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " alu_res"}, alu_res, 32'd0);
        chk({tag, " status_reg"}, {28'd0, status_reg}, 32'd0);
        chk({tag, " ctrl"}, {29'd0, wb_en_mem, mem_read_mem, mem_write_mem}, 32'd0);
        chk({tag, " val_Rm_mem"}, val_Rm_mem, 32'd0);
        chk({tag, " dest_mem"}, {28'd0, dest_mem}, 32'd0);
    endtask

    // Monitor: one scoreboard entry per clock edge that stimulus scheduled.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("alu_res", alu_res, e.alu);
                chk("status_reg", {28'd0, status_reg}, {28'd0, e.st});
                chk("ctrl", {29'd0, wb_en_mem, mem_read_mem, mem_write_mem},
                    {29'd0, e.wb, e.mr, e.mw});
                chk("val_Rm_mem", val_Rm_mem, e.rm);
                chk("dest_mem", {28'd0, dest_mem}, {28'd0, e.dst});
            end
        end
    end

    task automatic drive(input logic [3:0] cmd, input logic immv, input logic sv,
                         input logic [11:0] so, input logic [31:0] rn, input logic [31:0] rm,
                         input logic [3:0] dst, input logic [3:0] stin,
                         input logic wbv, input logic mrv, input logic mwv,
                         input logic bv, input logic frz,
                         input logic [31:0] ea, input logic [3:0] es);
        exe_cmd = cmd; imm = immv; S = sv; shift_operand = so; val_Rn = rn; val_Rm = rm;
        dest = dst; status_in = stin; wb_en = wbv; mem_read_en = mrv; mem_write_en = mwv;
        B = bv; freeze = frz;
        if (!frz) begin
            cur.alu = ea; cur.wb = wbv; cur.mr = mrv; cur.mw = mwv; cur.rm = rm; cur.dst = dst;
        end
        cur.st = es;
        exp_q.push_back(cur);
    endtask

    task automatic issue(input logic [3:0] cmd, input logic immv, input logic sv,
                         input logic [11:0] so, input logic [31:0] rn, input logic [31:0] rm,
                         input logic [3:0] dst, input logic [3:0] stin,
                         input logic wbv, input logic mrv, input logic mwv,
                         input logic bv, input logic frz,
                         input logic [31:0] ea, input logic [3:0] es);
        drive(cmd, immv, sv, so, rn, rm, dst, stin, wbv, mrv, mwv, bv, frz, ea, es);
        @(negedge clk);
    endtask

    initial begin
        cur = '{alu: 32'd0, st: 4'd0, wb: 1'b0, mr: 1'b0, mw: 1'b0, rm: 32'd0, dst: 4'd0};
        rst = 1'b0; wb_en = 1'b0; mem_read_en = 1'b0; mem_write_en = 1'b0; B = 1'b0;
        S = 1'b0; imm = 1'b0; freeze = 1'b0; exe_cmd = 4'd0; dest = 4'd0; status_in = 4'd0;
        PC = 32'd0; val_Rn = 32'd0; val_Rm = 32'd0; shift_operand = 12'd0;
        signed_imm_24 = 24'd0;
        #2;
        chk_all_zero("reset");
        chk("reset branch_taken", {31'd0, branch_taken}, 32'd0);
        @(negedge clk);
        chk_all_zero("reset held");

        // Release between edges; outputs must stay 0 until the next edge.
        rst = 1'b1;
        drive(4'b0010, 1'b1, 1'b0, 12'h007, 32'd5, 32'h0000_AAAA, 4'd3, 4'b0000,
              1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd12, 4'b0000);
        #2;
        chk_all_zero("release");
        @(negedge clk);

        //    cmd      imm   S     so       rn             rm             dst   stin     wb    mr    mw    B     frz   exp alu        exp st
        issue(4'b0001, 1'b1, 1'b1, 12'h2FF, 32'd0,         32'd0,         4'd1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hF000_000F, 4'b1000);
        issue(4'b0100, 1'b1, 1'b1, 12'h003, 32'd3,         32'd0,         4'd2, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,         4'b0110);
        issue(4'b0010, 1'b1, 1'b1, 12'h001, 32'h7FFF_FFFF, 32'd0,         4'd4, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 4'b1001);
        issue(4'b0001, 1'b0, 1'b0, 12'h200, 32'd0,         32'h0000_00F1, 4'd5, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0F10, 4'b1001);
        issue(4'b0001, 1'b0, 1'b0, 12'h420, 32'd0,         32'h8000_1200, 4'd6, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0080_0012, 4'b1001);
        issue(4'b0001, 1'b0, 1'b0, 12'h240, 32'd0,         32'h8000_0000, 4'd7, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hF800_0000, 4'b1001);
        issue(4'b0001, 1'b0, 1'b0, 12'h460, 32'd0,         32'h1234_5678, 4'd8, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7812_3456, 4'b1001);
        issue(4'b0001, 1'b0, 1'b0, 12'h070, 32'd0,         32'hDEAD_BEEF, 4'd9, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 4'b1001);
        issue(4'b0010, 1'b0, 1'b0, 12'hABC, 32'h0000_1000, 32'h0000_0077, 4'd10,4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1ABC, 4'b1001);
        issue(4'b0011, 1'b1, 1'b1, 12'h0FF, 32'hFFFF_FF00, 32'd0,         4'd11,4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,         4'b0110);
        issue(4'b0101, 1'b1, 1'b1, 12'h003, 32'd10,        32'd0,         4'd12,4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd6,         4'b0010);
        issue(4'b0110, 1'b0, 1'b1, 12'h000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd13,4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00F0_00F0, 4'b0011);
        issue(4'b0111, 1'b0, 1'b0, 12'h000, 32'h0000_0001, 32'h8000_0000, 4'd14,4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0001, 4'b0011);
        issue(4'b1000, 1'b0, 1'b0, 12'h000, 32'hFFFF_0000, 32'hFFFF_FFFF, 4'd15,4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_FFFF, 4'b0011);
        issue(4'b1001, 1'b1, 1'b1, 12'h000, 32'd0,         32'd0,         4'd1, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'b1001);
        issue(4'b1111, 1'b1, 1'b1, 12'h0AA, 32'h1234_0000, 32'd0,         4'd2, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,         4'b0111);
        issue(4'b0100, 1'b1, 1'b1, 12'h001, 32'h8000_0000, 32'd0,         4'd3, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 4'b0011);

        // Branch: target is combinational, control bits still flow to EXE/MEM.
        PC = 32'h0000_0100; signed_imm_24 = 24'hFFFFFE;
        drive(4'b0001, 1'b1, 1'b0, 12'h055, 32'd0, 32'h0000_0042, 4'd4, 4'b0000,
              1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0055, 4'b0011);
        #1;
        chk("branch_taken", {31'd0, branch_taken}, 32'd1);
        chk("branch_address", branch_address, 32'h0000_00F8);
        @(negedge clk);
        PC = 32'h0000_1000; signed_imm_24 = 24'h000010;
        drive(4'b0001, 1'b1, 1'b0, 12'h012, 32'd0, 32'h0000_0033, 4'd5, 4'b0000,
              1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0012, 4'b0011);
        #1;
        chk("branch_taken low", {31'd0, branch_taken}, 32'd0);
        chk("branch_address fwd", branch_address, 32'h0000_1040);
        @(negedge clk);

        // Freeze with a flag-setting ADD: nothing may move.
        issue(4'b0010, 1'b1, 1'b1, 12'h001, 32'd1,         32'h0000_0099, 4'd9, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0,         4'b0011);
        issue(4'b0100, 1'b1, 1'b1, 12'h005, 32'd1,         32'h0000_0088, 4'd8, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0,         4'b0011);
        issue(4'b0010, 1'b1, 1'b1, 12'h001, 32'd1,         32'h0000_0011, 4'd6, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2,         4'b0000);
        issue(4'b0001, 1'b1, 1'b1, 12'h0C3, 32'd0,         32'h0000_5555, 4'd7, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_00C3, 4'b0000);

        // Asynchronous reset between edges, with freeze asserted meanwhile.
        #2;
        rst = 1'b0; freeze = 1'b1;
        cur = '{alu: 32'd0, st: 4'd0, wb: 1'b0, mr: 1'b0, mw: 1'b0, rm: 32'd0, dst: 4'd0};
        #1;
        chk_all_zero("async reset");
        @(negedge clk);
        chk_all_zero("reset over edge");
        rst = 1'b1;
        drive(4'b0100, 1'b1, 1'b1, 12'h020, 32'h0000_0010, 32'h0000_0123, 4'd12, 4'b0000,
              1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 4'b1000);
        #2;
        chk_all_zero("post-release");
        @(negedge clk);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
